// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: computes a-b (mod 2^WIDTH) one bit per cycle, LSB first,
// with a start/busy/done handshake and registered result and final borrow.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  // State bits double as the busy/done flops, so both outputs come straight from registers.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic             br_nxt;
  logic             bit_d;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             load;
  logic             step;

  // Full-subtractor on the current operand LSBs plus the next result shift value.
  always_comb begin
    bit_d    = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_nxt  = WIDTH'({bit_d, res} >> 1);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE:    load = start;
      RUN:     step = 1'b1;
      default: ;
    endcase
  end

  assign busy = state[0];
  assign done = state[1];

  // Operand/result shifters; diff and borrow_out only move on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_nxt;
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff       <= res_nxt;
        borrow_out <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances checked against an arithmetic model.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  int checks;
  int errors;
  logic [7:0] last_diff;
  logic       last_borrow;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #3;
    checks++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
    end
    checks++;
    if ({busy1, done1, diff1, borrow1} !== 4'd0) begin
      errors++;
      $display("FAIL reset_w1: got busy=%b done=%b diff=%b borrow=%b, want all 0", busy1, done1, diff1, borrow1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_diff = 8'h00;
    last_borrow = 1'b0;
  endtask

  // One WIDTH=8 operation; operands are scrambled during RUN, optionally start is re-pulsed too.
  task automatic test_op(input logic [7:0] av, input logic [7:0] bv, input bit disturb, input string tag);
    logic [7:0] ed;
    logic       eb;
    ed = av - bv;
    eb = (av < bv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run_cycle%0d: busy=%b done=%b, want busy=1 done=0", tag, i, busy, done);
      end
      checks++;
      if (diff !== last_diff || borrow_out !== last_borrow) begin
        errors++;
        $display("FAIL %s hold_cycle%0d: diff=%h borrow=%b, want %h/%b", tag, i, diff, borrow_out, last_diff, last_borrow);
      end
      a = 8'($urandom);
      b = 8'($urandom);
      start = (disturb && i == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== ed || borrow_out !== eb) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b diff=%h borrow=%b, want done=1 busy=0 diff=%h borrow=%b",
               tag, done, busy, diff, borrow_out, ed, eb);
    end
    last_diff = ed;
    last_borrow = eb;
    if (disturb) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s start_in_done: busy=%b done=%b, want 0/0", tag, busy, done);
      end
    end
  endtask

  task automatic test_vectors();
    test_op(8'h5A, 8'h23, 1'b0, "vec_5a_23");
    test_op(8'h00, 8'h01, 1'b0, "vec_00_01");
    test_op(8'hFF, 8'hFF, 1'b0, "vec_ff_ff");
    test_op(8'h5A, 8'h23, 1'b1, "ignore_start");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      test_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
    end
    last_diff = 8'h00;
    last_borrow = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_held: busy=%b done=%b, want 0/0", busy, done);
      end
    end
    rst_n = 1'b1;
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_run%0d: busy=%b done=%b, want 1/0", i, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'h0F || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_result: done=%b diff=%h borrow=%b, want 1/0f/0", done, diff, borrow_out);
    end
    last_diff = 8'h0F;
    last_borrow = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_busy;
    logic exp_done;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h01;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      exp_done = ((i % 10) == 9);
      exp_busy = ((i % 10) >= 1) && ((i % 10) <= 8);
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        errors++;
        $display("FAIL b2b_cycle%0d: busy=%b done=%b, want %b/%b", i, busy, done, exp_busy, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (diff !== 8'h0F || borrow_out !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result%0d: diff=%h borrow=%b, want 0f/0", i, diff, borrow_out);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    last_diff = 8'h0F;
    last_borrow = 1'b0;
  endtask

  task automatic test_width1();
    logic [1:0] ab [4];
    logic [1:0] t;
    logic       ed;
    logic       eb;
    ab[0] = 2'b00; ab[1] = 2'b10; ab[2] = 2'b01; ab[3] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      t = ab[k];
      ed = t[1] ^ t[0];
      eb = (t[1] < t[0]);
      @(negedge clk);
      start1 = 1'b1; a1 = t[1]; b1 = t[0];
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = ~b1;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_run_ab%b: busy=%b done=%b, want 1/0", t, busy1, done1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== ed || borrow1 !== eb) begin
        errors++;
        $display("FAIL w1_result_ab%b: done=%b busy=%b diff=%b borrow=%b, want 1/0/%b/%b",
                 t, done1, busy1, diff1, borrow1, ed, eb);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vectors();
    test_random();
    test_mid_reset();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
